uart_rx_os: RTL

Oversampling UART receiver, successor to the single-rate receiver. Parametrised in data width, oversampling ratio and stop-bit count. Validates the start bit and samples each bit at its centre. Delivers each frame through a valid/ready handshake with framing, optional parity and overrun status. Sits between the baud-tick generator and the byte-consuming logic (FIFO or command decoder).

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx_os.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types, parameter limits and parity helper used by
//               the receiver and the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver frame phases. PARITY is only entered when parity is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_rx_state_t;

  // Legal parameter ranges for the UART blocks.
  localparam int unsigned c_DATA_BITS_MIN  = 5;
  localparam int unsigned c_DATA_BITS_MAX  = 9;
  localparam int unsigned c_OVERSAMPLE_MIN = 8;
  localparam int unsigned c_OVERSAMPLE_MAX = 32;
  localparam int unsigned c_STOP_BITS_MIN  = 1;
  localparam int unsigned c_STOP_BITS_MAX  = 2;

  // Parity bit that accompanies a payload: even parity makes the total count
  // of ones even, odd parity makes it odd. Unused upper bits must be zero.
  function automatic logic uart_parity_bit(input logic [15:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for an asynchronous serial line. Both
//               flops reset to 1 so an idle-high line never looks like a
//               start bit while coming out of reset.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_os
// Description : Oversampling UART receiver. Validates the start bit at its
//               centre, samples every bit at its centre, and presents each
//               frame on a valid/ready handshake with framing, parity and
//               overrun status.
// Options     : UART_RX_PARITY_EN - adds a parity bit after the payload, the
//               parity_odd input and the parity_err check. Without it
//               parity_err is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 tick,
`ifdef UART_RX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned c_SMP_W = $clog2(OVERSAMPLE);
  localparam int unsigned c_BIT_W = $clog2(DATA_BITS + 1);

  // Sample-counter values: half a bit after the start edge, then full bits.
  localparam logic [c_SMP_W-1:0] c_SMP_HALF = c_SMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_SMP_W-1:0] c_SMP_LAST = c_SMP_W'(OVERSAMPLE - 1);
  localparam logic [c_BIT_W-1:0] c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);
  localparam logic [c_BIT_W-1:0] c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

  // --------------------------------------------------------------------------
  // Line synchroniser
  // --------------------------------------------------------------------------
  logic w_rx_s;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(rx),
    .sync_o (w_rx_s)
  );

  // --------------------------------------------------------------------------
  // Frame FSM state
  // --------------------------------------------------------------------------
  uart_rx_state_t           state_q,   state_d;
  logic [c_SMP_W-1:0]       smp_cnt_q, smp_cnt_d;
  logic [c_BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]     shift_q,   shift_d;
  logic                     ferr_acc_q, ferr_acc_d;
  logic                     armed_q,   armed_d;

  // Frame completion strobe and the final status values it carries.
  logic                     w_frame_done;
  logic                     w_ferr_final;
  logic                     w_perr_final;
  logic                     w_smp_edge;

  // A bit-centre sample happens on a tick when the counter reaches its end.
  assign w_smp_edge = tick && (smp_cnt_q == c_SMP_LAST);

`ifdef UART_RX_PARITY_EN
  logic perr_acc_q, perr_acc_d;
  assign w_perr_final = perr_acc_q;
`else
  assign w_perr_final = 1'b0;
`endif

  // Frame-level state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      smp_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ferr_acc_q <= 1'b0;
      armed_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
      perr_acc_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      smp_cnt_q  <= smp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      ferr_acc_q <= ferr_acc_d;
      armed_q    <= armed_d;
`ifdef UART_RX_PARITY_EN
      perr_acc_q <= perr_acc_d;
`endif
    end
  end

  // Next-state logic: start validation, centre sampling and stop checking.
  always_comb begin
    state_d      = state_q;
    smp_cnt_d    = smp_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    ferr_acc_d   = ferr_acc_q;
    w_frame_done = 1'b0;
    w_ferr_final = ferr_acc_q;
`ifdef UART_RX_PARITY_EN
    perr_acc_d   = perr_acc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // A break that ended the previous frame must return high before
        // a new start edge is accepted.
        if (tick && !w_rx_s && armed_q) begin
          state_d    = ST_START;
          smp_cnt_d  = '0;
          bit_cnt_d  = '0;
          ferr_acc_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_acc_d = 1'b0;
`endif
        end
      end

      ST_START: begin
        if (tick) begin
          if (smp_cnt_q == c_SMP_HALF) begin
            // Line back high at mid start bit: a glitch, drop silently.
            smp_cnt_d = '0;
            state_d   = w_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            smp_cnt_d = smp_cnt_q + c_SMP_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (w_smp_edge) begin
            smp_cnt_d = '0;
            // LSB arrives first, so shift right and insert at the top.
            shift_d   = {w_rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == c_DATA_LAST) begin
              bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d   = ST_PARITY;
`else
              state_d   = ST_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + c_BIT_W'(1);
            end
          end else begin
            smp_cnt_d = smp_cnt_q + c_SMP_W'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (w_smp_edge) begin
            smp_cnt_d  = '0;
            perr_acc_d = (w_rx_s != uart_parity_bit(16'(shift_q), parity_odd));
            state_d    = ST_STOP;
          end else begin
            smp_cnt_d = smp_cnt_q + c_SMP_W'(1);
          end
        end
      end
`endif

      ST_STOP: begin
        if (tick) begin
          if (w_smp_edge) begin
            smp_cnt_d    = '0;
            ferr_acc_d   = ferr_acc_q | ~w_rx_s;
            w_ferr_final = ferr_acc_q | ~w_rx_s;
            if (bit_cnt_q == c_STOP_LAST) begin
              bit_cnt_d    = '0;
              w_frame_done = 1'b1;
              state_d      = ST_IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + c_BIT_W'(1);
            end
          end else begin
            smp_cnt_d = smp_cnt_q + c_SMP_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Break suppression: disarm when a frame ends on a low line, re-arm on high.
  always_comb begin
    armed_d = armed_q;
    if (w_frame_done && !w_rx_s) begin
      armed_d = 1'b0;
    end else if (w_rx_s) begin
      armed_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Output holding register and handshake
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
  logic                 rx_valid_q,   rx_valid_d;
  logic                 frame_err_q,  frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q,    overrun_d;

  // Load a finished frame if the holding register is free this cycle,
  // otherwise keep the old frame and flag the loss.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q && !rx_ready;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = 1'b0;

    if (w_frame_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        rx_valid_d   = 1'b1;
        frame_err_d  = w_ferr_final;
        parity_err_d = w_perr_final;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire
